// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin owner of the register-file command port.
// Ports: i_req_* / o_req_ready (requesters), o_res_* / i_res_ready (results),
//   o_rf_* / i_rf_* (register file). Option: REG_ARB_WRITE_PRIO_EN.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [4*NUM_REQ-1:0]          i_req_reg,
  input  logic [2*NUM_REQ-1:0]          i_req_cmd,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_res_valid,
  output logic [DATA_WIDTH-1:0]         o_res_data,
  input  logic [NUM_REQ-1:0]            i_res_ready,
  output logic                          o_rf_valid,
  output logic [3:0]                    o_rf_reg,
  output logic [1:0]                    o_rf_cmd,
  output logic [DATA_WIDTH-1:0]         o_rf_data,
  input  logic                          i_rf_ready,
  input  logic                          i_rf_res_valid,
  input  logic [DATA_WIDTH-1:0]         i_rf_data,
  output logic                          o_rf_res_ready
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETURN
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [3:0]            rf_reg_q, rf_reg_d;
  logic [1:0]            rf_cmd_q, rf_cmd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_found;

  // Rotating priority scan starting at ptr.
  always_comb begin
    int idx;
    idx       = 0;
    cand      = i_req_valid;
`ifdef REG_ARB_WRITE_PRIO_EN
    begin
      logic [NUM_REQ-1:0] wr;
      wr = '0;
      for (int k = 0; k < NUM_REQ; k++)
        wr[k] = i_req_valid[k] && (i_req_cmd[2*k +: 2] == 2'd1);
      // Pending writebacks retire ahead of operand traffic.
      if (|wr) cand = wr;
    end
`endif
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && cand[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[PW-1:0];
      end
    end
    gnt_oh = '0;
    if (gnt_found) gnt_oh[gnt_idx] = 1'b1;
  end

  always_comb begin
    int g;
    g          = int'(gnt_idx);
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    rf_reg_d   = rf_reg_q;
    rf_cmd_d   = rf_cmd_q;
    rf_data_d  = rf_data_q;
    res_data_d = res_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          owner_d   = gnt_idx;
          rf_reg_d  = i_req_reg[4*g +: 4];
          rf_cmd_d  = i_req_cmd[2*g +: 2];
          rf_data_d = i_req_data[DATA_WIDTH*g +: DATA_WIDTH];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_rf_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_rf_res_valid) begin
          res_data_d = i_rf_data;
          state_d    = S_RETURN;
        end
      end
      S_RETURN: begin
        if (i_res_ready[owner_q]) begin
          if (int'(owner_q) == NUM_REQ - 1) ptr_d = '0;
          else ptr_d = owner_q + 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      rf_reg_q   <= '0;
      rf_cmd_q   <= '0;
      rf_data_q  <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      rf_reg_q   <= rf_reg_d;
      rf_cmd_q   <= rf_cmd_d;
      rf_data_q  <= rf_data_d;
      res_data_q <= res_data_d;
    end
  end

  // Grant is combinational, so mask it while reset is held.
  always_comb begin
    o_req_ready = '0;
    if (state_q == S_IDLE && !reset) o_req_ready = gnt_oh;
    o_res_valid = '0;
    if (state_q == S_RETURN) o_res_valid[owner_q] = 1'b1;
  end

  assign o_rf_valid     = (state_q == S_ISSUE);
  assign o_rf_res_ready = (state_q == S_WAIT);
  assign o_rf_reg       = rf_reg_q;
  assign o_rf_cmd       = rf_cmd_q;
  assign o_rf_data      = rf_data_q;
  assign o_res_data     = res_data_q;

endmodule
